// File: rtl/configure.sv
// Build-time configuration for uart_tx_ctrl.
//   hardware       : 1 = full write / wait-done / clear handshake with uart_tx
//   uart_ctrl_data : write pushes a byte into the transmit FIFO
//   uart_ctrl_stat : status (count/empty/full/busy); also uart_tx's status address
//   uart_ctrl_ctrl : control (bit 0 = irq enable)
package configure;

    localparam logic        hardware       = 1'b1;
    localparam logic [63:0] uart_ctrl_data = 64'd0;
    localparam logic [63:0] uart_ctrl_stat = 64'd8;
    localparam logic [63:0] uart_ctrl_ctrl = 64'd16;

endpackage

// File: rtl/wires.sv
// Shared bus record types and the drain-FSM state encoding for uart_tx_ctrl.
//   mem_in_type          : request (valid, addr, wdata, wstrb)
//   mem_out_type         : response (ready, error, rdata)
//   uart_ctrl_state_type : drain FSM states
package wires;

    typedef struct packed {
        logic        mem_valid;
        logic [63:0] mem_addr;
        logic [63:0] mem_wdata;
        logic [7:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic        mem_error;
        logic [63:0] mem_rdata;
    } mem_out_type;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_ACK,
        WAIT_DONE,
        CLEAR,
        CLEAR_ACK
    } uart_ctrl_state_type;

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO for the transmit path; head is presented combinationally.
//   clock, reset : system clock, synchronous active-low reset
//   push, wdata  : enqueue a byte (ignored when full)
//   pop          : dequeue the head (ignored when empty)
//   rdata        : current head
//   count        : occupancy, 0..depth
//   empty, full  : derived from the registered count
module uart_fifo #(
    parameter int depth = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [7:0]             wdata,
    output logic [7:0]             rdata,
    output logic [$clog2(depth):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int aw = $clog2(depth);
    localparam int cw = aw + 1;
    localparam logic [aw:0] cap = depth[aw:0];

    logic [7:0]    mem [depth];
    logic [aw-1:0] wptr;
    logic [aw-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == cap);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    // Storage is data only and is not reset.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers wrap naturally because depth is a power of two.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + aw'(1);
            end
            if (do_pop) begin
                rptr <= rptr + aw'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + cw'(1);
                2'b01:   count <= count - cw'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// Buffered transmit controller in front of uart_tx: bytes written by the core
// are queued and handed to uart_tx one at a time with the full write,
// wait-for-done and clear-ready handshake.
//   clock, reset : system clock, synchronous active-low reset
//   ctrl_in/out  : register port from/to the core (data, status, control)
//   uart_out/in  : memory port to/from uart_tx
//   tx_irq_in    : uart_tx byte-done flag
//   irq          : FIFO drained and idle, gated by the irq enable bit
module uart_tx_ctrl
    import wires::*;
    import configure::*;
#(
    parameter int depth = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  mem_in_type  ctrl_in,
    output mem_out_type ctrl_out,
    output mem_in_type  uart_out,
    input  mem_out_type uart_in,
    input  logic        tx_irq_in,
    output logic        irq
);

    localparam int cw = $clog2(depth) + 1;

    typedef struct packed {
        uart_ctrl_state_type state;
        logic                ie;
        logic                irq;
        mem_out_type         ctrl_out;
        mem_in_type          uart_out;
    } reg_type;

    localparam reg_type init_reg = '0;

    reg_type       r;
    reg_type       rin;
    logic          push;
    logic          pop;
    logic [7:0]    head;
    logic [cw-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          wr;
    logic [63:0]   status_word;
    logic          unused_bits;

    uart_fifo #(
        .depth(depth)
    ) fifo (
        .clock(clock),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .wdata(ctrl_in.mem_wdata[7:0]),
        .rdata(head),
        .count(fifo_count),
        .empty(fifo_empty),
        .full (fifo_full)
    );

    assign wr          = |ctrl_in.mem_wstrb;
    assign status_word = {45'b0, (r.state != IDLE), fifo_full, fifo_empty, 16'(fifo_count)};
    assign unused_bits = ^{ctrl_in.mem_wdata[63:8], uart_in.mem_error, uart_in.mem_rdata};

    always_comb begin : comb
        reg_type v;
        v    = r;
        push = 1'b0;
        pop  = 1'b0;

        // Register port: response is registered, so it appears the cycle after the request.
        v.ctrl_out = '0;
        if (ctrl_in.mem_valid) begin
            v.ctrl_out.mem_ready = 1'b1;
            case (ctrl_in.mem_addr)
                uart_ctrl_data: begin
                    if (wr) begin
                        // Full is judged on the registered count, so a same-cycle pop does not make room.
                        if (fifo_full) begin
                            v.ctrl_out.mem_error = 1'b1;
                        end else begin
                            push = 1'b1;
                        end
                    end
                end
                uart_ctrl_stat: begin
                    if (!wr) begin
                        v.ctrl_out.mem_rdata = status_word;
                    end
                end
                uart_ctrl_ctrl: begin
                    if (wr) begin
                        v.ie = ctrl_in.mem_wdata[0];
                    end else begin
                        v.ctrl_out.mem_rdata = {63'b0, r.ie};
                    end
                end
                default: begin
                    v.ctrl_out.mem_error = 1'b1;
                end
            endcase
        end

        // Drain FSM: uart_out is loaded on entry to SEND/CLEAR, so each
        // request lasts exactly the one cycle spent in that state.
        v.uart_out = '0;
        case (r.state)
            IDLE: begin
                if (!fifo_empty) begin
                    v.state              = SEND;
                    v.uart_out.mem_valid = 1'b1;
                    v.uart_out.mem_addr  = uart_ctrl_data;
                    v.uart_out.mem_wstrb = 8'hFF;
                    v.uart_out.mem_wdata = {56'b0, head};
                end
            end
            SEND: begin
                pop     = 1'b1;
                v.state = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (uart_in.mem_ready) begin
                    v.state = hardware ? WAIT_DONE : IDLE;
                end
            end
            WAIT_DONE: begin
                if (tx_irq_in) begin
                    // Reading uart_tx status clears its ready flag.
                    v.state              = CLEAR;
                    v.uart_out.mem_valid = 1'b1;
                    v.uart_out.mem_addr  = uart_ctrl_stat;
                end
            end
            CLEAR: begin
                v.state = CLEAR_ACK;
            end
            CLEAR_ACK: begin
                if (uart_in.mem_ready) begin
                    v.state = IDLE;
                end
            end
            default: begin
                v.state = IDLE;
            end
        endcase

        // The new enable takes effect on irq in the same edge it is written.
        v.irq = v.ie && fifo_empty && (r.state == IDLE);

        rin = v;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r <= init_reg;
        end else begin
            r <= rin;
        end
    end

    assign ctrl_out = r.ctrl_out;
    assign uart_out = r.uart_out;
    assign irq      = r.irq;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl with a behavioural uart_tx responder
// and a byte scoreboard on the uart_out write stream.
module tb_uart_tx_ctrl;
    import wires::*;

    logic        clock = 1'b0;
    logic        reset;
    mem_in_type  ctrl_in;
    mem_out_type ctrl_out;
    mem_in_type  uart_out;
    mem_out_type uart_in;
    logic        tx_irq_in;
    logic        irq;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  exp_q[$];
    logic        stall = 1'b0;
    int          sent = 0;
    int          clears = 0;

    uart_tx_ctrl #(
        .depth(16)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .ctrl_in  (ctrl_in),
        .ctrl_out (ctrl_out),
        .uart_out (uart_out),
        .uart_in  (uart_in),
        .tx_irq_in(tx_irq_in),
        .irq      (irq)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge with the registered response.
    task automatic bus_xfer(input logic [63:0] addr, input logic [63:0] wdata, input logic [7:0] wstrb,
                            output logic [63:0] rdata, output logic rdy, output logic err);
        ctrl_in.mem_valid = 1'b1;
        ctrl_in.mem_addr  = addr;
        ctrl_in.mem_wdata = wdata;
        ctrl_in.mem_wstrb = wstrb;
        @(negedge clock);
        rdata   = ctrl_out.mem_rdata;
        rdy     = ctrl_out.mem_ready;
        err     = ctrl_out.mem_error;
        ctrl_in = '0;
    endtask

    task automatic push_byte(input logic [7:0] b, input logic accept);
        logic [63:0] rd;
        logic        rdy;
        logic        err;
        bus_xfer(64'd0, {56'b0, b}, 8'h01, rd, rdy, err);
        check("push_ready", 64'(rdy), 64'd1);
        check("push_error", 64'(err), 64'(!accept));
        if (accept) begin
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_idle(input string tag);
        logic [63:0] rd;
        logic        rdy;
        logic        err;
        int          n;
        n = 0;
        do begin
            bus_xfer(64'd8, 64'd0, 8'h00, rd, rdy, err);
            n++;
        end while ((rd[18] || !rd[16]) && n < 400);
        check({tag, "_idle"}, 64'(rd[18:16]), 64'b001);
    endtask

    // uart_tx model: registered ack, byte-done flag 3 cycles after a write ack
    // (held off while stalled), flag cleared by the status read.
    initial begin : uart_model
        logic pend_ack;
        logic pend_wr;
        logic wait_done;
        int   done_cnt;
        pend_ack  = 1'b0;
        pend_wr   = 1'b0;
        wait_done = 1'b0;
        done_cnt  = 0;
        uart_in   = '0;
        tx_irq_in = 1'b0;
        forever begin
            @(negedge clock);
            uart_in.mem_ready = 1'b0;
            if (!reset) begin
                pend_ack  = 1'b0;
                wait_done = 1'b0;
                done_cnt  = 0;
                tx_irq_in = 1'b0;
            end else begin
                if (pend_ack) begin
                    uart_in.mem_ready = 1'b1;
                    pend_ack = 1'b0;
                    if (pend_wr) begin
                        wait_done = 1'b1;
                        done_cnt  = 3;
                    end else begin
                        tx_irq_in = 1'b0;
                    end
                end else if (wait_done && !stall) begin
                    done_cnt--;
                    if (done_cnt == 0) begin
                        tx_irq_in = 1'b1;
                        wait_done = 1'b0;
                    end
                end
                if (uart_out.mem_valid) begin
                    pend_ack = 1'b1;
                    pend_wr  = |uart_out.mem_wstrb;
                end
            end
        end
    end

    initial begin : monitor
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clock);
            if (uart_out.mem_valid) begin
                check("valid_gap", 64'(prev_valid), 64'd0);
                if (|uart_out.mem_wstrb) begin
                    check("tx_addr", uart_out.mem_addr, 64'd0);
                    check("tx_wstrb", 64'(uart_out.mem_wstrb), 64'hFF);
                    check("tx_queue_nonempty", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        check("tx_byte", uart_out.mem_wdata, {56'b0, exp_q.pop_front()});
                    end
                    sent++;
                end else begin
                    check("clr_addr", uart_out.mem_addr, 64'd8);
                    clears++;
                end
            end
            prev_valid = uart_out.mem_valid;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        logic [63:0] rd;
        logic        rdy;
        logic        err;
        logic        seen_busy;
        int          s0;
        int          c0;

        reset   = 1'b0;
        ctrl_in = '0;
        repeat (3) @(negedge clock);
        check("rst_ctrl_resp", 64'({ctrl_out.mem_ready, ctrl_out.mem_error}), 64'd0);
        check("rst_ctrl_rdata", ctrl_out.mem_rdata, 64'd0);
        check("rst_uart_valid", 64'(uart_out.mem_valid), 64'd0);
        check("rst_uart_wstrb", 64'(uart_out.mem_wstrb), 64'd0);
        check("rst_irq", 64'(irq), 64'd0);
        reset = 1'b1;
        @(negedge clock);
        bus_xfer(64'd8, 64'd0, 8'h00, rd, rdy, err);
        check("rst_status", rd, 64'h1_0000);
        bus_xfer(64'd16, 64'd0, 8'h00, rd, rdy, err);
        check("rst_ie", rd, 64'd0);

        // Single byte, exact latency and handshake
        s0 = sent;
        c0 = clears;
        push_byte(8'h41, 1'b1);
        check("t1_no_early_tx", 64'(uart_out.mem_valid), 64'd0);
        @(negedge clock);
        check("t1_ready_pulse", 64'(ctrl_out.mem_ready), 64'd0);
        check("t1_tx_valid", 64'(uart_out.mem_valid), 64'd1);
        check("t1_tx_data", uart_out.mem_wdata, 64'h41);
        wait_idle("t1");
        check("t1_sent", 64'(sent - s0), 64'd1);
        check("t1_clear", 64'(clears - c0), 64'd1);

        // Fill with the UART stalled, overflow, then drain
        stall = 1'b1;
        s0 = sent;
        for (int i = 0; i < 16; i++) begin
            push_byte(i[7:0], 1'b1);
        end
        bus_xfer(64'd8, 64'd0, 8'h00, rd, rdy, err);
        check("t2_count15", 64'(rd[15:0]), 64'd15);
        check("t2_not_full", 64'(rd[17]), 64'd0);
        push_byte(8'h10, 1'b1);
        push_byte(8'h11, 1'b0);
        bus_xfer(64'd8, 64'd0, 8'h00, rd, rdy, err);
        check("t2_count16", 64'(rd[15:0]), 64'd16);
        check("t2_full", 64'(rd[17]), 64'd1);
        stall = 1'b0;
        wait_idle("t2");
        check("t2_sent", 64'(sent - s0), 64'd17);
        check("t2_q_drained", 64'(exp_q.size()), 64'd0);

        // Address decode corners
        bus_xfer(64'd24, 64'd0, 8'h00, rd, rdy, err);
        check("bad_addr_ready", 64'(rdy), 64'd1);
        check("bad_addr_error", 64'(err), 64'd1);
        check("bad_addr_rdata", rd, 64'd0);
        bus_xfer(64'd8, 64'hFFFF_FFFF, 8'hFF, rd, rdy, err);
        check("stat_wr_ready", 64'(rdy), 64'd1);
        check("stat_wr_error", 64'(err), 64'd0);
        bus_xfer(64'd8, 64'd0, 8'h00, rd, rdy, err);
        check("stat_wr_nochange", rd, 64'h1_0000);
        bus_xfer(64'd16, 64'd0, 8'h00, rd, rdy, err);
        check("stat_wr_ie", rd, 64'd0);
        bus_xfer(64'd0, 64'd0, 8'h00, rd, rdy, err);
        check("data_rd_rdata", rd, 64'd0);
        check("data_rd_error", 64'(err), 64'd0);

        // Interrupt: idle+empty with enable, tracks FSM through a handshake
        bus_xfer(64'd16, 64'd1, 8'h01, rd, rdy, err);
        bus_xfer(64'd16, 64'd0, 8'h00, rd, rdy, err);
        check("ie_readback", rd, 64'd1);
        @(negedge clock);
        check("irq_idle", 64'(irq), 64'd1);
        push_byte(8'h5A, 1'b1);
        seen_busy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bus_xfer(64'd8, 64'd0, 8'h00, rd, rdy, err);
            check("irq_track", 64'(irq), 64'(rd[16] && !rd[18]));
            if (rd[18]) begin
                seen_busy = 1'b1;
            end
        end
        check("irq_seen_busy", 64'(seen_busy), 64'd1);
        check("irq_final", 64'(irq), 64'd1);
        bus_xfer(64'd16, 64'd0, 8'h01, rd, rdy, err);
        check("irq_disable", 64'(irq), 64'd0);

        // Reset while waiting for byte-done with 3 bytes queued
        bus_xfer(64'd16, 64'd1, 8'h01, rd, rdy, err);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_byte(8'hA0 + i[7:0], 1'b1);
        end
        bus_xfer(64'd8, 64'd0, 8'h00, rd, rdy, err);
        check("pre_rst_count", 64'(rd[15:0]), 64'd3);
        check("pre_rst_busy", 64'(rd[18]), 64'd1);
        reset = 1'b0;
        @(negedge clock);
        check("mid_rst_uart_valid", 64'(uart_out.mem_valid), 64'd0);
        check("mid_rst_irq", 64'(irq), 64'd0);
        check("mid_rst_ctrl_ready", 64'(ctrl_out.mem_ready), 64'd0);
        exp_q.delete();
        stall = 1'b0;
        reset = 1'b1;
        bus_xfer(64'd8, 64'd0, 8'h00, rd, rdy, err);
        check("post_rst_status", rd, 64'h1_0000);
        bus_xfer(64'd16, 64'd0, 8'h00, rd, rdy, err);
        check("post_rst_ie", rd, 64'd0);
        s0 = sent;
        push_byte(8'h55, 1'b1);
        wait_idle("post_rst");
        check("post_rst_sent", 64'(sent - s0), 64'd1);

        repeat (3) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
